param_seq_detector: RTL and testbench
=====================================

// Module: param_seq_detector
//
// PURPOSE
//   Serial bit-stream pattern detector. Generalises the fixed-pattern single-input
//   sequence detector (clk, rst, j -> w) to:
//   - a parametrised pattern and length;
//   - run-time overlap / non-overlap mode;
//   - a sample enable;
//   - a saturating match counter with synchronous clear.
//   Sits directly on a serial input line; w pulses once per detected occurrence.
//
// PARAMETERS
//   LEN      4        pattern length in bits; legal range 2..16
//   PATTERN  4'b1011  LEN-bit pattern; MSB is the oldest bit received
//   CNT_W    8        match-counter width; saturates at 2**CNT_W-1
//
// PORTS
//   clk    in   1      single clock; all state changes on rising edge
//   rst    in   1      asynchronous, active-low reset
//   en     in   1      sample enable; j is consumed only on edges where en=1
//   j      in   1      serial data bit
//   ovl    in   1      1 = overlapping detection, 0 = non-overlapping
//   clr    in   1      synchronous clear of count (does not affect detection)
//   w      out  1      registered match pulse, high 1 cycle per match
//   count  out  CNT_W  number of matches since reset/clr, saturating
//
// BEHAVIOUR
//   - Reset (rst=0, asynchronous, any time incl. mid-pattern):
//     hist=0, fcnt=0, w=0, count=0. Partial matches are discarded.
//   - State:
//     - hist[LEN-1:0]: last LEN accepted bits.
//     - fcnt: valid-bit fill count, range 0..LEN, saturating at LEN.
//   - nxt = {hist[LEN-2:0], j}
//   - hit = en && (fcnt >= LEN-1) && (nxt == PATTERN)
//   - Rising edge, en=1:
//     - hist <= nxt.
//     - fcnt <= hit && !ovl ? 0 : min(fcnt+1, LEN).
//   - Rising edge, en=0: hist and fcnt hold.
//   - w <= hit on every edge. Latency: w is high in the cycle after the edge that
//     sampled the last pattern bit. w is never high two cycles unless both edges hit.
//   - Overlap mode: the tail of a match may start the next match.
//   - Non-overlap mode: after a hit the next match needs LEN fresh bits.
//   - ovl may change at any time. It is sampled on the same edge as j and applies
//     to that edge's fcnt update.
//   - count:
//     - if clr: count <= 0. clr wins over a simultaneous hit; that hit is not
//       counted, but w still pulses.
//     - else if hit && count != max: count <= count+1.
//     - at max: count holds. No wrap to 0.
//   - Leading zeros: hist resets to 0, but fcnt gating prevents a false match on an
//     all-zero PATTERN before LEN bits have arrived.
//   - An LEN value outside 2..16 is an elaboration error (generate-time check).
//
// TESTING  (LEN=4, PATTERN=1011, CNT_W=8 unless noted)
//   1. Reset release, en=1, ovl=1, j=1,0,1,1,0,1,1 on 7 edges
//      -> w high after edges 4 and 7 only; count=2.
//   2. Same stream, ovl=0
//      -> w high after edge 4 only; count=1. Continue 0,1,1 -> w after edge 10;
//         count=2.
//   3. en=0 between bits: j=1,0,(en=0 for 3 edges, j toggling),1,1
//      -> gaps ignored; w after the 4th enabled edge; count=1.
//   4. Assert rst=0 asynchronously between clock edges after bits 1,0,1
//      -> w=0 and count=0 immediately. Then bit 1 alone -> no w. The full 1011
//         again -> w.
//   5. clr=1 on the same edge as a hit with count=5
//      -> w=1 next cycle, count=0. Next hit -> count=1.
//   6. CNT_W=2, ovl=1, repeated 1011011011...
//      -> count reaches 3 and holds at 3; w keeps pulsing every 3 edges.

Source files
------------

// File: rtl/param_seq_detector.sv
// param_seq_detector: serial bit-stream matcher for a LEN-bit PATTERN.
// Run-time overlap mode, sample enable, and a saturating match counter.
`default_nettype none

module param_seq_detector #(
   parameter int              LEN     = 4,
   parameter logic [LEN-1:0]  PATTERN = 4'b1011,
   parameter int              CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             j,
   input  logic             ovl,
   input  logic             clr,
   output logic             w,
   output logic [CNT_W-1:0] count
);

   localparam int              FW      = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   generate
      if (LEN < 2 || LEN > 16) begin : g_bad_len
         $error("param_seq_detector: LEN must be in 2..16");
      end
   endgenerate

   logic [LEN-1:0]   hist_q, hist_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic             w_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [LEN-1:0]   nxt;
   logic             hit;

   assign nxt = {hist_q[LEN-2:0], j};
   // fcnt gating keeps the reset-zero history from matching an all-zero pattern
   assign hit = en && (fcnt_q >= FW'(LEN - 1)) && (nxt == PATTERN);

   always_comb begin
      hist_d  = hist_q;
      fcnt_d  = fcnt_q;
      count_d = count_q;
      if (en) begin
         hist_d = nxt;
         if (hit && !ovl)
            fcnt_d = '0;
         else if (fcnt_q != FW'(LEN))
            fcnt_d = fcnt_q + 1'b1;
      end
      // A clear beats a coincident hit; that hit still pulses w but is not counted
      if (clr)
         count_d = '0;
      else if (hit && count_q != CNT_MAX)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q  <= '0;
         fcnt_q  <= '0;
         w_q     <= 1'b0;
         count_q <= '0;
      end else begin
         hist_q  <= hist_d;
         fcnt_q  <= fcnt_d;
         w_q     <= hit;
         count_q <= count_d;
      end
   end

   assign w     = w_q;
   assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector (LEN=4, PATTERN=1011), plus a CNT_W=2 copy.
`default_nettype none

module tb_param_seq_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       j   = 1'b0;
   logic       ovl = 1'b1;
   logic       clr = 1'b0;
   logic       w, w2;
   logic [7:0] count;
   logic [1:0] count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   param_seq_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .j(j), .ovl(ovl), .clr(clr),
      .w(w), .count(count)
   );

   param_seq_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .j(j), .ovl(ovl), .clr(clr),
      .w(w2), .count(count2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one bit, take one edge, then check w just after the edge
   task automatic step(input logic b, input logic ew, input string tag);
      j = b;
      @(posedge clk);
      #1;
      chk(tag, {31'd0, w}, {31'd0, ew});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #3;
      rst = 1'b1;
   endtask

   initial begin
      logic [6:0] s1_bits, s1_w;
      logic [9:0] s2_bits, s2_w;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_w", {31'd0, w}, 32'd0);
      chk("reset_count", {24'd0, count}, 32'd0);
      rst = 1'b1;

      // Test 1: overlapping, 1011011
      en = 1'b1; ovl = 1'b1;
      s1_bits = 7'b1011011;
      s1_w    = 7'b0001001;
      for (int i = 6; i >= 0; i--) step(s1_bits[i], s1_w[i], $sformatf("t1_w_e%0d", 7 - i));
      chk("t1_count", {24'd0, count}, 32'd2);

      // Test 2: non-overlapping, 1011011011
      do_reset();
      ovl = 1'b0;
      s2_bits = 10'b1011011011;
      s2_w    = 10'b0001000001;
      for (int i = 9; i >= 0; i--) begin
         step(s2_bits[i], s2_w[i], $sformatf("t2_w_e%0d", 10 - i));
         if (i == 3) chk("t2_count_e7", {24'd0, count}, 32'd1);
      end
      chk("t2_count_e10", {24'd0, count}, 32'd2);

      // Test 3: enable gaps are ignored
      do_reset();
      ovl = 1'b1;
      step(1'b1, 1'b0, "t3_e1");
      step(1'b0, 1'b0, "t3_e2");
      en = 1'b0;
      step(1'b1, 1'b0, "t3_gap1");
      step(1'b0, 1'b0, "t3_gap2");
      step(1'b1, 1'b0, "t3_gap3");
      en = 1'b1;
      step(1'b1, 1'b0, "t3_e3");
      step(1'b1, 1'b1, "t3_e4");
      chk("t3_count", {24'd0, count}, 32'd1);

      // Test 4: asynchronous reset mid-pattern discards history
      step(1'b1, 1'b0, "t4_pre1");
      step(1'b0, 1'b0, "t4_pre2");
      step(1'b1, 1'b0, "t4_pre3");
      #2;
      rst = 1'b0;
      #1;
      chk("t4_async_count", {24'd0, count}, 32'd0);
      chk("t4_async_w", {31'd0, w}, 32'd0);
      #1;
      rst = 1'b1;
      step(1'b1, 1'b0, "t4_lone1");
      step(1'b1, 1'b0, "t4_b1");
      step(1'b0, 1'b0, "t4_b2");
      step(1'b1, 1'b0, "t4_b3");
      step(1'b1, 1'b1, "t4_b4");
      chk("t4_count", {24'd0, count}, 32'd1);

      // Test 5: clear on the same edge as a hit
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, "t5_fill0");
         step(1'b1, 1'b0, "t5_fill1");
         step(1'b1, 1'b1, "t5_fill_hit");
      end
      chk("t5_count5", {24'd0, count}, 32'd5);
      step(1'b0, 1'b0, "t5_c0");
      step(1'b1, 1'b0, "t5_c1");
      clr = 1'b1;
      step(1'b1, 1'b1, "t5_clr_hit_w");
      clr = 1'b0;
      chk("t5_clr_count", {24'd0, count}, 32'd0);
      step(1'b0, 1'b0, "t5_n0");
      step(1'b1, 1'b0, "t5_n1");
      step(1'b1, 1'b1, "t5_n_hit");
      chk("t5_count_after", {24'd0, count}, 32'd1);

      // Test 6: narrow counter saturates at 3, w keeps pulsing
      do_reset();
      ovl = 1'b1;
      step(1'b1, 1'b0, "t6_lead");
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 1'b0, "t6_b0");
         step(1'b1, 1'b0, "t6_b1");
         step(1'b1, 1'b1, "t6_hit");
         chk("t6_w2", {31'd0, w2}, 32'd1);
         chk("t6_count2", {30'd0, count2}, (k < 3) ? k : 3);
      end
      chk("t6_count_wide", {24'd0, count}, 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
